// File: rtl/descrambler_pkg.sv
// Shared types and constants for the 16FSK receive descrambler and its LFSR core.
package descrambler_pkg;

  localparam int unsigned LFSR_W = 10;
  localparam int unsigned TAP_HI = 9;
  localparam int unsigned TAP_LO = 6;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 10'b0001011101;

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  // One step of x^10 + x^7 + 1: shift up, feedback enters at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_LO] ^ s[TAP_HI]};
  endfunction

endpackage

// File: rtl/lfsr10.sv
// 10-bit keystream LFSR with load and advance controls; shared with the transmit scrambler.
module lfsr10
  import descrambler_pkg::*;
(
  input  logic              clk,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              advance,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk) begin
    if (load) begin
      state <= seed;
    end else if (advance) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/descrambler.sv
// Frame-sync hunter and payload descrambler for the 16FSK receive path.
// Optional macro DESCRAMBLER_SYNC_TOL_EN accepts sync words with up to one bit error.
module descrambler
  import descrambler_pkg::*;
#(
  parameter int unsigned       SYNC_LEN  = 16,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_LEN'(16'hEB90),
  parameter int unsigned       FRAME_LEN = 256,
  parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              datain,
  input  logic              din_en,
  output logic              dataout,
  output logic              dout_valid,
  output logic              frame_start,
  output logic              frame_end,
  output logic              sync_lock,
  output logic [LFSR_W-1:0] reg_scr
);

  localparam int unsigned FILL_W = $clog2(SYNC_LEN + 1);
  localparam int unsigned CNT_W  = 16;

  state_t              state, state_nxt;
  logic [SYNC_LEN-1:0] sr, sr_nxt, shifted_c;
  logic [FILL_W-1:0]   fill, fill_nxt, fill_inc_c;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                match_c, load_c, adv_c, out_en_c, first_c, last_c;

  assign shifted_c  = {sr[SYNC_LEN-2:0], datain};
  assign fill_inc_c = (fill == FILL_W'(SYNC_LEN)) ? fill : fill + FILL_W'(1);

  // Match is judged on the register contents including the bit being accepted.
`ifdef DESCRAMBLER_SYNC_TOL_EN
  assign match_c = (fill_inc_c == FILL_W'(SYNC_LEN)) &&
                   ($countones(shifted_c ^ SYNC_WORD) <= 1);
`else
  assign match_c = (fill_inc_c == FILL_W'(SYNC_LEN)) && (shifted_c == SYNC_WORD);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      sr    <= '0;
      fill  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      fill  <= fill_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    fill_nxt  = fill;
    cnt_nxt   = cnt;
    load_c    = 1'b0;
    adv_c     = 1'b0;
    out_en_c  = 1'b0;
    first_c   = 1'b0;
    last_c    = 1'b0;
    case (state)
      HUNT: begin
        if (din_en) begin
          sr_nxt   = shifted_c;
          fill_nxt = fill_inc_c;
          if (match_c) begin
            state_nxt = PAYLOAD;
            load_c    = 1'b1;
            cnt_nxt   = '0;
          end
        end
      end
      PAYLOAD: begin
        if (din_en) begin
          adv_c    = 1'b1;
          out_en_c = 1'b1;
          first_c  = (cnt == '0);
          cnt_nxt  = cnt + CNT_W'(1);
          // Hunting restarts from an empty register so no sync straddles the payload.
          if (cnt == CNT_W'(FRAME_LEN - 1)) begin
            last_c    = 1'b1;
            state_nxt = HUNT;
            sr_nxt    = '0;
            fill_nxt  = '0;
            cnt_nxt   = '0;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dataout     <= 1'b0;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      sync_lock   <= 1'b0;
    end else begin
      if (out_en_c) begin
        dataout <= datain ^ reg_scr[0];
      end
      dout_valid  <= out_en_c;
      frame_start <= first_c;
      frame_end   <= last_c;
      sync_lock   <= (state_nxt == PAYLOAD);
    end
  end

  lfsr10 u_lfsr (
    .clk     (clk),
    .load    (rst | load_c),
    .seed    (SEED),
    .advance (adv_c),
    .state   (reg_scr)
  );

endmodule
